hmc960_target: RTL and testbench

- Serial-target (responder) end of the HMC960 SEN/SCLK/SDI/SDO interface. It is used as an on-FPGA loopback and bench partner for the HMC960 master.
- Oversamples the bus on the 50 MHz system clock, decodes 32-bit frames and applies writes to an internal register file.
- Returns register contents on SDO using the HMC960 read-pointer scheme: a write to register 0 selects which register is read back.
- Exposes a write-strobe side port so other logic can observe committed writes.

---
 rtl/hmc960_target.sv | 157 +++++++++++++++
 tb/tb_hmc960_target.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/hmc960_target.sv
// hmc960_target -- serial target (responder) for the HMC960 SEN/SCLK/SDI/SDO bus.
// Oversamples the bus on clk. It decodes 32-bit MSB-first frames in the form
// {data[23:0], reg_addr[4:0], chip[2:0]} and writes them into a register file.
// Read data goes out on SDO through the read-pointer scheme: a write to
// register 0 chooses which register the next frame shifts out.
//
// Ports:
//   clk        system clock (50 MHz)
//   reset      synchronous, active-high
//   sclk/sen/sdi  serial bus from the master (asynchronous to clk, sen active low)
//   sdo        serial data back to the master
//   wr_strobe  one-cycle pulse per committed write; wr_addr/wr_data hold it
//   frame_err  one-cycle pulse per discarded frame
//   busy       high while a frame is being shifted
module hmc960_target #(
    parameter int         BITS        = 32,
    parameter logic [2:0] CHIP_ADDR   = 3'b110,
    parameter int         NUM_REGS    = 32,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sclk,
    input  logic        sen,
    input  logic        sdi,
    output logic        sdo,
    output logic        wr_strobe,
    output logic [4:0]  wr_addr,
    output logic [23:0] wr_data,
    output logic        frame_err,
    output logic        busy
);
    localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT, COMMIT} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sclk_sync, sen_sync, sdi_sync;
    logic                   sclk_d, sen_d;
    logic [BITS-1:0]        in_sr, out_sr;
    logic [5:0]             bit_cnt;
    logic [4:0]             rd_ptr;
    logic [23:0]            regs [NUM_REGS];
    logic [23:0]            rd_data;

    // All three inputs pass through the same synchronizer depth, so sdi keeps
    // its alignment with sclk.
    logic sclk_s, sen_s, sdi_s;
    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign sen_s  = sen_sync[SYNC_STAGES-1];
    assign sdi_s  = sdi_sync[SYNC_STAGES-1];

    logic sclk_rise, sclk_fall, sen_rise, sen_fall;
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign sen_rise  = sen_s & ~sen_d;
    assign sen_fall  = ~sen_s & sen_d;

    logic [4:0]  in_addr;
    logic [23:0] in_data;
    logic        frame_ok;
    assign in_addr  = in_sr[7:3];
    assign in_data  = in_sr[BITS-1:8];
    assign frame_ok = (bit_cnt == 6'(BITS)) && (in_sr[2:0] == CHIP_ADDR);

    // Register 0 reads back the pointer itself. Addresses outside the file read as zero.
    always_comb begin
        rd_data = '0;
        if (rd_ptr == 5'd0)
            rd_data = {19'd0, rd_ptr};
        else if (int'(rd_ptr) < NUM_REGS)
            rd_data = regs[rd_ptr[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= WAIT_IDLE;
            sclk_sync <= '0;
            sen_sync  <= '0;
            sdi_sync  <= '0;
            sclk_d    <= 1'b0;
            sen_d     <= 1'b0;
            in_sr     <= '0;
            out_sr    <= '0;
            bit_cnt   <= '0;
            rd_ptr    <= '0;
            sdo       <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            sen_sync  <= {sen_sync[SYNC_STAGES-2:0], sen};
            sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], sdi};
            sclk_d    <= sclk_s;
            sen_d     <= sen_s;
            wr_strobe <= 1'b0;
            frame_err <= 1'b0;

            case (state)
                // After reset, wait for the bus to go idle so that a transfer
                // already in flight cannot be taken as a frame.
                WAIT_IDLE: begin
                    busy <= 1'b0;
                    sdo  <= 1'b0;
                    if (sen_s) state <= IDLE;
                end
                IDLE: begin
                    sdo <= 1'b0;
                    if (sen_fall) begin
                        bit_cnt <= '0;
                        out_sr  <= {rd_data, 8'h00};
                        sdo     <= rd_data[23];
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (sclk_rise) begin
                        in_sr <= {in_sr[BITS-2:0], sdi_s};
                        if (bit_cnt != 6'(BITS + 1)) bit_cnt <= bit_cnt + 6'd1;
                    end
                    // The master has already sampled sdo on its own falling
                    // edge, so the next bit is presented after the synchronized fall.
                    if (sclk_fall) begin
                        out_sr <= {out_sr[BITS-2:0], 1'b0};
                        sdo    <= out_sr[BITS-2];
                    end
                    // An sclk rise in this same cycle is still counted above,
                    // because COMMIT reads the registered result.
                    if (sen_rise) begin
                        sdo   <= 1'b0;
                        busy  <= 1'b0;
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    sdo <= 1'b0;
                    if (frame_ok) begin
                        wr_strobe <= 1'b1;
                        wr_addr   <= in_addr;
                        wr_data   <= in_data;
                        if (int'(in_addr) < NUM_REGS) regs[in_addr[AW-1:0]] <= in_data;
                        if (in_addr == 5'd0) rd_ptr <= in_data[4:0];
                    end else begin
                        frame_err <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= WAIT_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hmc960_target.sv
`timescale 1ns/1ps
module tb_hmc960_target;
    localparam int         NREGS = 8;
    localparam logic [2:0] CHIP  = 3'b110;

    logic        clk = 1'b0;
    logic        reset, sclk, sen, sdi;
    logic        sdo, wr_strobe, frame_err, busy;
    logic [4:0]  wr_addr;
    logic [23:0] wr_data;

    hmc960_target #(.BITS(32), .CHIP_ADDR(CHIP), .NUM_REGS(NREGS), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .sclk(sclk), .sen(sen), .sdi(sdi), .sdo(sdo),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_err(frame_err), .busy(busy)
    );

    always #10 clk = ~clk;

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference model: register contents plus the read pointer, updated one
    // frame at a time.
    typedef struct { bit err; logic [4:0] addr; logic [23:0] data; } ev_t;
    ev_t         exp_q[$];
    logic [31:0] exp_rx[$], act_rx[$];
    logic [23:0] mregs [32];
    int          mptr;

    function automatic logic [23:0] mread();
        if (mptr == 0) return 24'(mptr);
        if (mptr < NREGS) return mregs[mptr];
        return 24'd0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        mptr = 0;
    endtask

    task automatic model_frame(input logic [31:0] w, input int nbits);
        ev_t e;
        int  a;
        a = int'(w[7:3]);
        if (nbits == 32 && w[2:0] == CHIP) begin
            e.err = 0; e.addr = w[7:3]; e.data = w[31:8];
            if (a < NREGS) mregs[a] = w[31:8];
            if (a == 0) mptr = int'(w[12:8]);
        end else begin
            e.err = 1; e.addr = '0; e.data = '0;
        end
        exp_q.push_back(e);
    endtask

    // Monitor: each strobe or error pulse is checked against the next expected
    // event. Readback words captured by the driver are checked the same way.
    always @(negedge clk) begin
        if (!reset && (wr_strobe || frame_err)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_event", {wr_strobe, frame_err}, 2'b00);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if (e.err) chk("frame_err_evt", {wr_strobe, frame_err}, 2'b01);
                else begin
                    chk("wr_strobe_evt", {wr_strobe, frame_err}, 2'b10);
                    chk("wr_addr", wr_addr, e.addr);
                    chk("wr_data", wr_data, e.data);
                end
            end
        end
        if (act_rx.size() > 0) begin
            logic [31:0] a, x;
            a = act_rx.pop_front();
            x = (exp_rx.size() > 0) ? exp_rx.pop_front() : 32'hx;
            chk("sdo_readback", a, x);
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Master side of one frame. When coinc is set, sen rises on the same clock
    // as the final sclk rise. A nonzero rst_at pulses reset after that many
    // sclk pulses while sen is still low.
    task automatic send_frame(input logic [31:0] w, input int nbits, input int half,
                              input bit coinc, input int rst_at, output logic [31:0] rx);
        rx  = '0;
        sen = 1'b0;
        for (int i = nbits - 1; i >= 0; i--) begin
            if (rst_at > 0 && (nbits - 1 - i) == rst_at) begin
                reset = 1'b1; wait_clk(3); reset = 1'b0; wait_clk(2);
            end
            sdi = (i < 32) ? w[i] : 1'b0;
            wait_clk(half);
            sclk = 1'b1;
            if (coinc && i == 0) sen = 1'b1;
            wait_clk(half);
            if (rst_at == 0 && i == nbits / 2) chk("busy_mid_frame", busy, 1'b1);
            rx   = {rx[30:0], sdo};
            sclk = 1'b0;
        end
        if (!coinc) begin
            wait_clk(half);
            sen = 1'b1;
        end
    endtask

    task automatic frame(input logic [31:0] w, input int nbits, input int half, input bit coinc);
        logic [31:0] rx;
        if (nbits == 32) exp_rx.push_back({mread(), 8'h00});
        model_frame(w, nbits);
        send_frame(w, nbits, half, coinc, 0, rx);
        if (nbits == 32) act_rx.push_back(rx);
        wait_clk(8);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [31:0] rx;
        reset = 1'b1; sen = 1'b1; sclk = 1'b0; sdi = 1'b0;
        model_clear();
        wait_clk(5);
        chk("rst_sdo", sdo, 1'b0);
        chk("rst_wr_strobe", wr_strobe, 1'b0);
        chk("rst_frame_err", frame_err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_wr_addr", wr_addr, 5'd0);
        chk("rst_wr_data", wr_data, 24'd0);
        reset = 1'b0;
        wait_clk(10);

        // Write reg1, point at reg1, then a dummy frame reads back 0xABCDE500.
        frame(32'hABCDE50E, 32, 4, 0);
        frame(32'h00000106, 32, 4, 0);
        frame(32'h00000106, 32, 4, 0);
        // A frame with the wrong chip address is discarded.
        frame(32'h1234560D, 32, 4, 0);
        frame(32'h00000106, 32, 4, 0);
        // Short and long frames are discarded and leave registers alone.
        frame(32'h5555550E, 31, 4, 0);
        frame(32'h5555550E, 33, 4, 0);
        frame(32'h00000106, 32, 4, 0);

        // Reset mid-frame: the frame is lost, and the registers and pointer clear.
        send_frame(32'h7777770E, 32, 4, 0, 12, rx);
        model_clear();
        wait_clk(10);
        chk("post_rst_wr_addr", wr_addr, 5'd0);
        chk("post_rst_wr_data", wr_data, 24'd0);
        frame(32'h2468AC0E, 32, 4, 0);
        frame(32'h00000106, 32, 4, 0);
        frame(32'h00000106, 32, 4, 0);

        // Out-of-range address: the write strobes, but reads back as zero.
        frame(32'hFFFFFFA6, 32, 4, 0);
        frame(32'h00001406, 32, 4, 0);
        frame(32'h00001406, 32, 4, 0);

        // Minimum sclk phase, with sen rising on the last sclk rise.
        frame(32'h5A5A5A16, 32, 3, 1);
        frame(32'h00000206, 32, 3, 1);
        frame(32'h00000206, 32, 3, 1);

        // Randomized traffic.
        for (int k = 0; k < 40; k++) begin
            logic [31:0] w;
            int          nb, r;
            w = $urandom;
            if ($urandom_range(0, 3) != 0) w[2:0] = CHIP;
            if ($urandom_range(0, 2) == 0) w[7:3] = 5'd0;
            r  = $urandom_range(0, 7);
            nb = (r == 0) ? 31 : (r == 1) ? 33 : 32;
            frame(w, nb, $urandom_range(3, 5), 1'($urandom_range(0, 1)));
        end

        wait_clk(20);
        chk("pending_events", exp_q.size(), 0);
        chk("pending_readbacks", exp_rx.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
